// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the IF-stage PC unit: control-flow type codes, reset PC and NOP.
// Used by fetch_pc_unit and npc_calc (build option PC_ALIGN_CHECK_EN lives in those files).
package fetch_pc_unit_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_J    = 3'd3;
    localparam logic [2:0] BR_JAL  = 3'd4;
    localparam logic [2:0] BR_JR   = 3'd5;
    localparam logic [2:0] BR_JALR = 3'd6;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// npc_calc: combinational next-PC select from the instruction currently in ID.
// With PC_ALIGN_CHECK_EN a misaligned jr/jalr target is flagged; without it the low bits are cleared.
module npc_calc
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic [ADDR_W-1:0] id_pc_i,
    input  logic [15:0]       imm16_i,
    input  logic [25:0]       idx26_i,
    input  logic [2:0]        br_type_i,
    input  logic              cmp_eq_i,
    input  logic              cmp_neq_i,
    input  logic [ADDR_W-1:0] rs_fwd_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              redirect_o,
    output logic              tgt_misalign_o
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] target;
    logic              taken;

    assign pc_plus4    = if_pc_i + ADDR_W'(4);
    assign id_pc_plus4 = id_pc_i + ADDR_W'(4);
    assign br_target   = id_pc_plus4 + {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};
    assign j_target    = {id_pc_plus4[ADDR_W-1:28], idx26_i, 2'b00};

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        case (br_type_i)
            BR_BEQ:         begin taken = cmp_eq_i;  target = br_target; end
            BR_BNE:         begin taken = cmp_neq_i; target = br_target; end
            BR_J, BR_JAL:   begin taken = 1'b1;      target = j_target;  end
            BR_JR, BR_JALR: begin taken = 1'b1;      target = rs_fwd_i;  end
            default:        ;
        endcase
    end

    assign redirect_o = taken;

`ifdef PC_ALIGN_CHECK_EN
    logic is_reg_jump;
    assign is_reg_jump    = (br_type_i == BR_JR) || (br_type_i == BR_JALR);
    assign tgt_misalign_o = taken && is_reg_jump && (target[1:0] != 2'b00);
    assign next_pc_o      = taken ? target : pc_plus4;
`else
    assign tgt_misalign_o = 1'b0;
    assign next_pc_o      = taken ? (target & ~ADDR_W'(3)) : pc_plus4;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage program counter plus IF/ID register, delay slot always executed, no flush.
// Build option PC_ALIGN_CHECK_EN: a misaligned jr/jalr freezes the PC and sets a sticky pc_misalign.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       im_instr,
    input  logic [2:0]        br_type,
    input  logic              cmp_eq,
    input  logic              cmp_neq,
    input  logic [ADDR_W-1:0] rs_fwd,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc8,
    output logic              redirect,
    output logic              pc_misalign
);

    logic [ADDR_W-1:0] if_pc_q,    if_pc_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] id_pc_q;
    logic              pc_misalign_q, pc_misalign_d;
    logic [ADDR_W-1:0] next_pc;
    logic              tgt_misalign;
    logic              fault;

    npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
        .if_pc_i        (if_pc_q),
        .id_pc_i        (id_pc_q),
        .imm16_i        (id_instr_q[15:0]),
        .idx26_i        (id_instr_q[25:0]),
        .br_type_i      (br_type),
        .cmp_eq_i       (cmp_eq),
        .cmp_neq_i      (cmp_neq),
        .rs_fwd_i       (rs_fwd),
        .next_pc_o      (next_pc),
        .redirect_o     (redirect),
        .tgt_misalign_o (tgt_misalign)
    );

    // tgt_misalign is constant 0 unless the alignment trap is built in, so fault then never fires.
    assign fault         = pc_misalign_q || tgt_misalign;
    assign if_pc_d       = fault ? if_pc_q : next_pc;
    assign id_instr_d    = fault ? NOP_INSTR : im_instr;
    assign pc_misalign_d = fault;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc_q       <= RESET_PC;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= RESET_PC;
            pc_misalign_q <= 1'b0;
        end else if (!stall) begin
            if_pc_q       <= if_pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= if_pc_q;
            pc_misalign_q <= pc_misalign_d;
        end
    end

    assign if_pc       = if_pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc8      = id_pc_q + ADDR_W'(8);
    assign pc_misalign = pc_misalign_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
IF-stage program counter and IF/ID pipeline register for the 5-stage MIPS core, with delay-slot semantics.
- Directly upstream of the ID-stage register comparator, which returns equal/not-equal back to this block.
- Selects next PC from PC+4, a branch target, a jump target or a register target, and drives instruction-memory fetch.
- Latches the fetched instruction and its PC into ID, honouring stall from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; the block is specified and tested only at 32.

Ports:
- clk  in  1  system clock, all state on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard-unit stall; freezes PC and the IF/ID register
- im_instr  in  32  instruction read combinationally from IM at if_pc
- br_type  in  3  ID-stage decoded control-flow type (encoding in package)
- cmp_eq  in  1  ID comparator: forwarded rs == rt
- cmp_neq  in  1  ID comparator: forwarded rs != rt
- rs_fwd  in  32  forwarded rs value in ID (jr/jalr target)
- if_pc  out  32  current fetch address to IM
- id_instr  out  32  instruction held in IF/ID
- id_pc  out  32  PC of id_instr
- id_pc8  out  32  id_pc+8, link value for jal/jalr
- redirect  out  1  combinational; 1 when the ID instruction changes control flow this cycle
- pc_misalign  out  1  see Optional Feature

Behaviour:
- Reset (sync, dominates stall):
  - if_pc=RESET_PC, id_instr=32'h0 (nop), id_pc=RESET_PC, id_pc8=RESET_PC+8, pc_misalign=0.
- br_type encoding: NONE=0, BEQ=1, BNE=2, J=3, JAL=4, JR=5, JALR=6; values 7 decode as NONE.
- Target computation (all from the ID instruction, with id_instr fields imm16=[15:0] and idx26=[25:0]):
  - BEQ/BNE: id_pc+4 + (sign_ext(imm16)<<2).
  - J/JAL: {id_pc_plus4[31:28], idx26, 2'b00}.
  - JR/JALR: rs_fwd.
- Taken conditions:
  - BEQ&&cmp_eq, BNE&&cmp_neq, J, JAL, JR, JALR.
  - redirect = taken.
  - If cmp_eq and cmp_neq are both 1 or both 0 (illegal), BEQ follows cmp_eq and BNE follows cmp_neq.
- next_pc = taken ? target : if_pc+4. Arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0, and so do branch offsets.
- Each rising edge, when not reset:
  - If stall=1: hold if_pc, id_instr, id_pc. redirect may still be asserted but has no effect.
  - Else: if_pc<=next_pc; id_instr<=im_instr; id_pc<=if_pc.
- Delay slot:
  - The instruction fetched in the same cycle a branch is in ID is always latched and executed.
  - There is no flush or annulment path.
- Latency: a branch in ID at cycle n makes if_pc=target at cycle n+1. The delay slot reaches ID at n+1 and the target reaches ID at n+2.
- Stall and a taken branch together: stall wins. The branch stays in ID and is re-evaluated with updated forwarded comparator inputs once the stall drops.
- id_pc8 = id_pc+8 is a combinational output of the register.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If a taken JR/JALR target has [1:0]!=0 while not stalled, if_pc holds and pc_misalign is set.
  - pc_misalign is sticky until reset, and PC stays frozen while it is set.
  - The IF/ID register loads nop (32'h0) from the following cycle.
- Undefined:
  - Target bits [1:0] are forced to 2'b00.
  - pc_misalign is tied 0.

Decomposition:
- Shared package contents:
  - br_type localparams (BR_NONE..BR_JALR).
  - RESET_PC default.
  - NOP encoding 32'h0.
- Sub-module npc_calc: combinational; inputs if_pc, id_pc, id_instr fields, br_type, cmp_eq/neq, rs_fwd; outputs next_pc, redirect.
- fetch_pc_unit instantiates npc_calc and owns the PC and IF/ID registers.

Test Plan:
- Reset then 3 free cycles, no branches:
  - if_pc 0x3000 -> 0x3004 -> 0x3008 -> 0x300C.
  - id_pc lags if_pc by one cycle; id_instr is 0 in the first cycle after reset.
- BEQ at 0x3004 with imm16=0x0003 and cmp_eq=1:
  - Next cycle if_pc=0x3014 and the delay slot (fetched from 0x3008) is in ID.
  - With cmp_eq=0 instead, if_pc=0x300C.
- BNE with imm16=0xFFFF, cmp_neq=1, id_pc=0x3010 -> if_pc=0x3010 (self-loop target).
- JAL at id_pc=0x3020 with idx26=0x0000C10 -> if_pc=0x0000_3040, id_pc8=0x3028.
- Stall during a taken JR (rs_fwd=0x3100) for 2 cycles -> if_pc and id_instr held both cycles; if_pc=0x3100 on the first unstalled edge.
- Reset asserted while stall=1 mid-branch -> registers return to reset values on that edge.
  - With PC_ALIGN_CHECK_EN: JR to 0x3102 sets pc_misalign=1, holds if_pc, and loads nop into ID.
